// File: rtl/delay_arb.sv
// Two-requester round-robin arbiter for one shared programmable delay engine.
// The winner's delay is latched at grant; ack pulses in DONE once it has elapsed.
module delay_arb #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] dly0,
    input  logic         req1,
    input  logic [W-1:0] dly1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         ack0,
    output logic         ack1,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic         ptr;   // last requester served
    logic         win;

    // On a tie the requester not served last wins; otherwise the sole requester.
    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ~ptr;
        else
            win = req1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= COUNT;
                        ptr   <= win;
                        cnt   <= win ? dly1 : dly0;
                        gnt0  <= ~win;
                        gnt1  <= win;
                    end
                end
                COUNT: begin
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

    // gnt identifies the owner, so ack is a pure decode of the registered state.
    always_comb begin
        ack0 = (state == DONE) && gnt0;
        ack1 = (state == DONE) && gnt1;
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_delay_arb.sv
// Randomised and directed bench for delay_arb against a transaction-level model
// (owner, latched delay, cycles since grant, last served).
module tb_delay_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] dly0 = '0, dly1 = '0;
    logic         gnt0, gnt1, ack0, ack1, busy;

    delay_arb #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .req0(req0),
        .dly0(dly0),
        .req1(req1),
        .dly1(dly1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .ack0(ack0),
        .ack1(ack1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a service lasts d+2 cycles from grant, ack on the last one.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_d     = 0;
    int m_t     = 0;
    int m_last  = 1;

    bit r0 = 1'b0, r1 = 1'b0;
    int d0 = 0, d1 = 0;
    bit auto_drop = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_gnt(input int who);
        return m_busy && (m_owner == who);
    endfunction

    function automatic bit exp_ack(input int who);
        return exp_gnt(who) && (m_t == m_d + 1);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 1;
        m_t    = 0;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (r0 || r1) begin
                if (r0 && r1) w = (m_last == 0) ? 1 : 0;
                else          w = r0 ? 0 : 1;
                m_owner = w;
                m_last  = w;
                m_d     = (w == 0) ? d0 : d1;
                m_t     = 0;
                m_busy  = 1'b1;
            end
        end else if (m_t == m_d + 1) begin
            m_busy = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_all();
        check("gnt0", 32'(gnt0), 32'(exp_gnt(0)));
        check("gnt1", 32'(gnt1), 32'(exp_gnt(1)));
        check("ack0", 32'(ack0), 32'(exp_ack(0)));
        check("ack1", 32'(ack1), 32'(exp_ack(1)));
        check("busy", 32'(busy), 32'(m_busy));
        check("mutex", 32'(gnt0 & gnt1), 32'd0);
    endtask

    // Called just after a falling edge: drive, take the rising edge, check.
    task automatic cycle();
        req0 = r0;
        req1 = r1;
        dly0 = W'(d0);
        dly1 = W'(d1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (auto_drop) begin
            if (exp_ack(0)) r0 = 1'b0;
            if (exp_ack(1)) r1 = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        r0 = 1'b0;
        r1 = 1'b0;
        rst = 1'b1;
        model_reset();
        run(2);
        rst = 1'b0;
    endtask

    // Counts cycles from the current grant until ack0, bounded.
    task automatic measure_ack0(input int expected, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            cycle();
            n++;
            if (ack0) seen = 1'b1;
        end
        check(tag, 32'(seen ? n : -1), 32'(expected));
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'({gnt0, gnt1, ack0, ack1}), 32'd0);
        do_reset();

        // Single requester, dly=3: ack four cycles after grant.
        auto_drop = 1'b1;
        r0 = 1'b1; d0 = 3; r1 = 1'b0;
        cycle();
        check("single_gnt0", 32'(gnt0), 32'd1);
        measure_ack0(4, "single_lat");
        run(3);

        // Zero delay on requester 1.
        r1 = 1'b1; d1 = 0;
        run(5);

        // Held tie: alternating grants.
        do_reset();
        auto_drop = 1'b0;
        r0 = 1'b1; r1 = 1'b1; d0 = 2; d1 = 1;
        run(24);

        // Delay changed after grant; the latched value governs.
        do_reset();
        auto_drop = 1'b1;
        r0 = 1'b1; d0 = 5; r1 = 1'b0;
        cycle();
        run(2);
        d0 = 1;
        measure_ack0(4, "dly_change_lat");
        run(3);

        // Asynchronous reset in the middle of a count.
        do_reset();
        auto_drop = 1'b0;
        r0 = 1'b1; d0 = 6; r1 = 1'b1; d1 = 2;
        run(3);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'({gnt0, gnt1, ack0, ack1, busy}), 32'd0);
        model_reset();
        r0 = 1'b0;
        @(negedge clk);
        run(1);
        rst = 1'b0;
        cycle();
        check("rst_gnt1", 32'(gnt1), 32'd1);
        run(6);

        // Maximum delay: ack sixteen cycles after grant.
        r1 = 1'b0;
        do_reset();
        auto_drop = 1'b1;
        r0 = 1'b1; d0 = 15;
        cycle();
        check("max_gnt0", 32'(gnt0), 32'd1);
        measure_ack0(16, "max_lat");
        run(2);

        // Random traffic with occasional early drops and resets.
        for (int i = 0; i < 3000; i++) begin
            if (!r0) r0 = ($urandom_range(0, 2) == 0);
            else if (exp_gnt(0) && $urandom_range(0, 15) == 0) r0 = 1'b0;
            if (!r1) r1 = ($urandom_range(0, 2) == 0);
            else if (exp_gnt(1) && $urandom_range(0, 15) == 0) r1 = 1'b0;
            d0 = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
            d1 = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
            auto_drop = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
